mem_sram_ctrl: RTL and testbench
================================

MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 1024, the byte address that maps to SRAM word 0.
REQ-002 SHALL have parameter SRAM_WAIT, default 2, the cycles each 16-bit half access is held (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have ports MEM_R_EN / MEM_W_EN  input  1 each  load / store request from the EX/MEM register.
REQ-006 SHALL have port ALU_result  input  32  byte address computed by the execute stage.
REQ-007 SHALL have port Val_Rm  input  32  store data.
REQ-008 SHALL have port ready  output  1  high when the current MEM-stage access completes this cycle or no access is pending.
REQ-009 SHALL have port freeze  output  1  equal to ~ready; stalls every pipeline register and the PC.
REQ-010 SHALL have port mem_read_data  output  32  loaded word; valid while ready is high in DONE after a read.
REQ-011 SHALL have ports SRAM_ADDR  output  18, SRAM_DQ_out  output  16, SRAM_DQ_in  input  16, SRAM_DQ_oe  output  1, SRAM_WE_N  output  1, SRAM_OE_N  output  1, for the external 16-bit SRAM.
REQ-012 SHALL have port align_err  output  1  misaligned or out-of-range access flag (see Configuration).

Function
REQ-013 States SHALL be IDLE, LO, HI, DONE; a wait counter SHALL count 0..SRAM_WAIT-1 within LO and HI.
REQ-014 IDLE SHALL go to LO when MEM_R_EN or MEM_W_EN is high; otherwise it SHALL stay in IDLE.
REQ-015 LO SHALL go to HI, and HI to DONE, when the counter reaches SRAM_WAIT-1; the counter SHALL clear on every state change.
REQ-016 DONE SHALL go to IDLE unconditionally after one cycle, so a request held by the frozen pipeline is not re-issued.
REQ-017 word address SHALL be (ALU_result - BASE_ADDR) >> 2, truncated to 17 bits; SRAM_ADDR SHALL be {word[16:0], 0} in LO and {word[16:0], 1} in HI.
REQ-018 Store: in LO/HI, SRAM_WE_N=0, SRAM_DQ_oe=1, SRAM_OE_N=1, SRAM_DQ_out=Val_Rm[15:0] in LO and Val_Rm[31:16] in HI.
REQ-019 Load: in LO/HI, SRAM_OE_N=0, SRAM_WE_N=1, SRAM_DQ_oe=0; SRAM_DQ_in SHALL be captured on the last cycle of LO into bits [15:0] and of HI into bits [31:16].
REQ-020 Outside LO/HI: SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0.
REQ-021 ready SHALL be combinational: high if neither request is asserted, or if the state is DONE; low otherwise.
REQ-022 Latency from the first request cycle in IDLE to ready high SHALL be 2*SRAM_WAIT+1 cycles.
REQ-023 If MEM_R_EN and MEM_W_EN are both high, the access SHALL be a store, and mem_read_data SHALL hold its previous value.
REQ-024 mem_read_data SHALL hold its value until the next load capture.
REQ-025 Inputs SHALL be sampled every cycle; the pipeline holds them stable while freeze is high.

Reset
REQ-026 rst high SHALL force IDLE, counter=0, mem_read_data=0, align_err=0, with SRAM controls inactive, in the following cycle. This applies even mid-access; a low half already written is not rolled back.

Configuration
REQ-027 With macro MEM_ALIGN_CHECK_EN defined, a request with ALU_result[1:0]!=0 or ALU_result<BASE_ADDR SHALL go IDLE->DONE with no SRAM access. In that DONE cycle it SHALL drive mem_read_data=0 and align_err=1 (latency 1).
REQ-028 With MEM_ALIGN_CHECK_EN undefined, the alignment and range checks SHALL be absent, address bits [1:0] SHALL be ignored, and align_err SHALL be tied to 0.

Verification (SRAM_WAIT=2, BASE_ADDR=1024)
REQ-029 Store ALU_result=1032, Val_Rm=0xDEADBEEF. Required response:
- SRAM_ADDR=4 with DQ 0xBEEF for 2 cycles, then SRAM_ADDR=5 with DQ 0xDEAD for 2 cycles, both with WE_N=0.
- ready high in cycle 5, freeze low in cycle 5.
REQ-030 Load ALU_result=1032 with SRAM returning 0xBEEF then 0xDEAD. Required response: mem_read_data=0xDEADBEEF and ready high in cycle 5.
REQ-031 No request for 10 cycles -> ready=1, freeze=0, SRAM_WE_N=SRAM_OE_N=1 throughout.
REQ-032 Request held through DONE, then replaced by a new load -> exactly one access per instruction, and the second access starts the cycle after IDLE.
REQ-033 rst pulsed during a store's HI phase -> next cycle: IDLE, SRAM_WE_N=1, mem_read_data=0; the following request completes normally.
REQ-034 With MEM_ALIGN_CHECK_EN defined, a load from 1033 -> align_err=1, mem_read_data=0, ready high in cycle 1, SRAM_OE_N stays 1.

Source files
------------

// File: rtl/mem_sram_ctrl.sv
// rtl/mem_sram_ctrl.sv - MEM-stage 32-bit access over a 16-bit SRAM as two half-word phases.
// Define MEM_ALIGN_CHECK_EN to reject misaligned / below-base addresses with align_err.
module mem_sram_ctrl #(
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned SRAM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Val_Rm,
  output logic        ready,
  output logic        freeze,
  output logic [31:0] mem_read_data,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        align_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] BASE = BASE_ADDR[31:0];
  localparam logic [3:0]  LAST = 4'(SRAM_WAIT - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        err_q;
  logic        req;
  logic        store;
  logic        last;
  logic        active;
  logic        hi;
  logic        bad;
  logic [31:0] off;
  logic [16:0] word;
  logic        unused_bits;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign store  = MEM_W_EN;
  assign last   = (cnt == LAST);
  assign active = (state == S_LO) || (state == S_HI);
  assign hi     = (state == S_HI);
  assign off    = ALU_result - BASE;
  assign word   = off[18:2];
  assign unused_bits = &{1'b0, off[31:19], off[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign bad = (ALU_result[1:0] != 2'b00) || (ALU_result < BASE);
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      err_q         <= 1'b0;
      mem_read_data <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt   <= 4'd0;
          err_q <= 1'b0;
          if (req) begin
            if (bad) begin
              state         <= S_DONE;
              err_q         <= 1'b1;
              mem_read_data <= 32'd0;
            end else begin
              state <= S_LO;
            end
          end
        end
        S_LO: begin
          if (last) begin
            state <= S_HI;
            cnt   <= 4'd0;
            if (!store) mem_read_data[15:0] <= SRAM_DQ_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_HI: begin
          if (last) begin
            state <= S_DONE;
            cnt   <= 4'd0;
            if (!store) mem_read_data[31:16] <= SRAM_DQ_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          // DONE always returns to IDLE so a request held by the frozen pipeline is not replayed
          state <= S_IDLE;
          cnt   <= 4'd0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = ~req | (state == S_DONE);
  assign freeze      = ~ready;
  assign align_err   = err_q;
  assign SRAM_ADDR   = active ? {word, hi} : 18'd0;
  assign SRAM_WE_N   = ~(active & store);
  assign SRAM_OE_N   = ~(active & ~store);
  assign SRAM_DQ_oe  = active & store;
  assign SRAM_DQ_out = (active & store) ? (hi ? Val_Rm[31:16] : Val_Rm[15:0]) : 16'd0;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb/tb_mem_sram_ctrl.sv - scoreboard bench for mem_sram_ctrl (SRAM_WAIT=2, BASE_ADDR=1024).
module tb_mem_sram_ctrl;

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic        err;
  } comp_t;

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [15:0] data;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_result, Val_Rm;
  logic        ready, freeze, align_err;
  logic [31:0] mem_read_data;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
  logic        SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N;

  logic [15:0] sram [0:63];
  comp_t       cq[$];
  bus_t        bq[$];
  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  logic [31:0] exp_rd = 32'd0;

  mem_sram_ctrl dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_result(ALU_result), .Val_Rm(Val_Rm), .ready(ready), .freeze(freeze),
    .mem_read_data(mem_read_data), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out),
    .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N), .align_err(align_err)
  );

  always #5 clk = ~clk;

  assign SRAM_DQ_in = (!SRAM_OE_N) ? sram[SRAM_ADDR[5:0]] : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus monitor: every SRAM cycle must match the next expected half access
  always @(negedge clk) begin
    if (!SRAM_WE_N || !SRAM_OE_N) begin
      if (bq.size() == 0) begin
        chk("bus_extra", {14'd0, SRAM_ADDR}, 32'hFFFF_FFFF);
      end else begin
        bus_t b;
        b = bq.pop_front();
        chk("bus_we", {31'd0, ~SRAM_WE_N}, {31'd0, b.we});
        chk("bus_addr", {14'd0, SRAM_ADDR}, {14'd0, b.addr});
        if (b.we) begin
          chk("bus_dq", {16'd0, SRAM_DQ_out}, {16'd0, b.data});
          chk("bus_oe", {31'd0, SRAM_DQ_oe}, 32'd1);
          sram[SRAM_ADDR[5:0]] = SRAM_DQ_out;
        end
      end
    end
  end

  // Completion monitor: counts stalled cycles and checks each completed access
  always @(negedge clk) begin
    if (!(MEM_R_EN || MEM_W_EN)) begin
      lat = 0;
    end else if (!ready) begin
      lat++;
    end else begin
      if (cq.size() == 0) begin
        chk("comp_extra", 32'd1, 32'd0);
      end else begin
        comp_t c;
        c = cq.pop_front();
        chk("latency", lat, c.lat);
        chk("rd_data", mem_read_data, c.data);
        chk("align_err", {31'd0, align_err}, {31'd0, c.err});
        chk("freeze_done", {31'd0, freeze}, 32'd0);
      end
      lat = 0;
    end
  end

  task automatic push_bus(input logic we, input logic [17:0] addr, input logic [15:0] data);
    bus_t b;
    b.we = we; b.addr = addr; b.data = data;
    bq.push_back(b); bq.push_back(b);
  endtask

  task automatic push_comp(input int l, input logic [31:0] d, input logic e);
    comp_t c;
    c.lat = l; c.data = d; c.err = e;
    cq.push_back(c);
  endtask

  // Issue a request right after a clock edge and hold it until ready is seen
  task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] v);
    int n;
    MEM_R_EN = r; MEM_W_EN = w; ALU_result = a; Val_Rm = v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 40);
    if (!ready) chk("req_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic req_off();
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sram[i] = 16'h0000;
    sram[8] = 16'h1234; sram[9] = 16'hABCD;
    sram[6] = 16'h5A5A; sram[7] = 16'hC3C3;
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_result = 32'd0; Val_Rm = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rd", mem_read_data, 32'd0);
    chk("rst_align", {31'd0, align_err}, 32'd0);
    chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ctl", {28'd0, ready, freeze, SRAM_WE_N, SRAM_OE_N}, 32'b1011);
    end
    @(posedge clk); #1;

    push_bus(1'b1, 18'd4, 16'hBEEF); push_bus(1'b1, 18'd5, 16'hDEAD);
    push_comp(5, exp_rd, 1'b0);
    do_req(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    req_off();
    @(posedge clk); #1;

    push_bus(1'b0, 18'd4, 16'h0); push_bus(1'b0, 18'd5, 16'h0);
    exp_rd = 32'hDEADBEEF;
    push_comp(5, exp_rd, 1'b0);
    do_req(1'b1, 1'b0, 32'd1032, 32'd0);
    req_off();
    @(posedge clk); #1;

    push_bus(1'b0, 18'd8, 16'h0); push_bus(1'b0, 18'd9, 16'h0);
    push_comp(5, 32'hABCD1234, 1'b0);
    push_bus(1'b0, 18'd6, 16'h0); push_bus(1'b0, 18'd7, 16'h0);
    push_comp(5, 32'hC3C35A5A, 1'b0);
    do_req(1'b1, 1'b0, 32'd1040, 32'd0);
    do_req(1'b1, 1'b0, 32'd1036, 32'd0);
    exp_rd = 32'hC3C35A5A;
    req_off();
    @(posedge clk); #1;

    push_bus(1'b1, 18'd10, 16'hF0F0); push_bus(1'b1, 18'd11, 16'h0F0F);
    push_comp(5, exp_rd, 1'b0);
    do_req(1'b1, 1'b1, 32'd1044, 32'h0F0FF0F0);
    req_off();
    @(posedge clk); #1;

`ifdef MEM_ALIGN_CHECK_EN
    exp_rd = 32'd0;
    push_comp(1, exp_rd, 1'b1);
    do_req(1'b1, 1'b0, 32'd1033, 32'd0);
`else
    push_bus(1'b0, 18'd4, 16'h0); push_bus(1'b0, 18'd5, 16'h0);
    exp_rd = 32'hDEADBEEF;
    push_comp(5, exp_rd, 1'b0);
    do_req(1'b1, 1'b0, 32'd1033, 32'd0);
`endif
    req_off();
    @(posedge clk); #1;

    // Store interrupted by reset after its first HI cycle
    push_bus(1'b1, 18'd4, 16'h2222);
    begin
      bus_t b;
      b.we = 1'b1; b.addr = 18'd5; b.data = 16'h1111;
      bq.push_back(b);
    end
    MEM_W_EN = 1'b1; ALU_result = 32'd1032; Val_Rm = 32'h11112222;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; req_off();
    @(negedge clk);
    chk("rst_mid_we", {31'd0, SRAM_WE_N}, 32'd1);
    chk("rst_mid_rd", mem_read_data, 32'd0);
    chk("rst_mid_addr", {14'd0, SRAM_ADDR}, 32'd0);
    @(posedge clk); #1;

    push_bus(1'b0, 18'd8, 16'h0); push_bus(1'b0, 18'd9, 16'h0);
    push_comp(5, 32'hABCD1234, 1'b0);
    do_req(1'b1, 1'b0, 32'd1040, 32'd0);
    req_off();
    repeat (4) @(posedge clk);
    #1;
    chk("bus_queue_empty", bq.size(), 32'd0);
    chk("comp_queue_empty", cq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
